regfile_write_arbiter: RTL and testbench

Sequences and shares the single write port of the 16x16-bit register file. After reset, and on demand, it clears every register to a programmable value. It then arbitrates round-robin between two write requesters: A, the core writeback, and B, the debug/loader port. All register-file write controls are driven from flops.

---
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Owns the register file's single write port. It runs a clear sequence after reset or on request,
// then arbitrates round-robin between core writeback (A) and the debug/loader port (B).
module regfile_write_arbiter #(
  parameter int unsigned NUM_REGS           = 16,
  parameter logic [15:0] INIT_VALUE         = 16'h0000,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        InitStart,
  input  logic        A_Valid,
  input  logic [3:0]  A_Reg,
  input  logic [15:0] A_Data,
  output logic        A_Ready,
  input  logic        B_Valid,
  input  logic [3:0]  B_Reg,
  input  logic [15:0] B_Data,
  output logic        B_Ready,
  output logic [3:0]  WriteRegister,
  output logic [15:0] WriteData,
  output logic        RegWrite,
  output logic        Busy
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(NUM_REGS - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;     // 0: A has priority on a tie, 1: B
  logic [3:0]  wreg_q, wreg_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;

  logic        run_open;
  logic        grant_a;
  logic        grant_b;
  logic [3:0]  sel_reg;
  logic [15:0] sel_data;
  logic        sel_dropped;

  always_comb begin
    run_open    = (state_q == ST_RUN) && !InitStart;
    grant_a     = run_open && A_Valid && (!B_Valid || !ptr_q);
    grant_b     = run_open && B_Valid && (!A_Valid ||  ptr_q);
    sel_reg     = grant_b ? B_Reg  : A_Reg;
    sel_data    = grant_b ? B_Data : A_Data;
    sel_dropped = ZERO_REG_HARDWIRED && (sel_reg == 4'd0);

    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    if (InitStart) begin
      state_d = ST_INIT;
      cnt_d   = 4'd0;
    end else if (state_q == ST_INIT) begin
      // Init writes bypass the register-0 drop rule so r0 is cleared as well.
      we_d    = 1'b1;
      wreg_d  = cnt_q;
      wdata_d = INIT_VALUE;
      if (cnt_q == LAST_CNT) begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (grant_a || grant_b) begin
      // A dropped write to r0 still counts as a grant for fairness.
      ptr_d = grant_a;
      if (!sel_dropped) begin
        we_d    = 1'b1;
        wreg_d  = sel_reg;
        wdata_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= 4'd0;
      ptr_q   <= 1'b0;
      wreg_q  <= 4'd0;
      wdata_q <= 16'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign A_Ready       = grant_a;
  assign B_Ready       = grant_b;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign RegWrite      = we_q;
  assign Busy          = (state_q == ST_INIT);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, multi-cycle sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_regfile_write_arbiter;

  localparam logic [15:0] INIT_VAL = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        InitStart = 1'b0;
  logic        A_Valid = 1'b0;
  logic [3:0]  A_Reg = 4'd0;
  logic [15:0] A_Data = 16'd0;
  logic        A_Ready;
  logic        B_Valid = 1'b0;
  logic [3:0]  B_Reg = 4'd0;
  logic [15:0] B_Data = 16'd0;
  logic        B_Ready;
  logic [3:0]  WriteRegister;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic        Busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NUM_REGS(16),
    .INIT_VALUE(INIT_VAL),
    .ZERO_REG_HARDWIRED(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .InitStart(InitStart),
    .A_Valid(A_Valid),
    .A_Reg(A_Reg),
    .A_Data(A_Data),
    .A_Ready(A_Ready),
    .B_Valid(B_Valid),
    .B_Reg(B_Reg),
    .B_Data(B_Data),
    .B_Ready(B_Ready),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .RegWrite(RegWrite),
    .Busy(Busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: init flag, clear index, priority owner, expected write outputs.
  bit m_init;
  int m_cnt;
  int m_ptr;
  bit m_we;
  int m_wreg;
  int m_wdata;
  bit smp_a, smp_b, acc_a, acc_b;

  typedef struct {
    bit          av;
    logic [3:0]  ar;
    logic [15:0] ad;
    bit          bv;
    logic [3:0]  br;
    logic [15:0] bd;
    bit          ea;
    bit          eb;
    bit          ewe;
    logic [3:0]  ereg;
    logic [15:0] edat;
    bit          chk;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_cnt = 0; m_ptr = 0; m_we = 1'b0; m_wreg = 0; m_wdata = 0;
    acc_a = 1'b0; acc_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_RegWrite", RegWrite, 0);
    check("rst_WriteRegister", WriteRegister, 0);
    check("rst_WriteData", WriteData, 0);
    check("rst_Busy", Busy, 1);
    check("rst_A_Ready", A_Ready, 0);
    check("rst_B_Ready", B_Ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: check handshake against the model, take the edge, check the registered write.
  task automatic cycle();
    int win;
    int r;
    #2;
    win = -1;
    if (!m_init && !InitStart) begin
      if (A_Valid && B_Valid) win = m_ptr;
      else if (A_Valid)       win = 0;
      else if (B_Valid)       win = 1;
    end
    smp_a = A_Ready;
    smp_b = B_Ready;
    check("A_Ready", A_Ready, (win == 0));
    check("B_Ready", B_Ready, (win == 1));
    check("Busy", Busy, m_init);
    acc_a = (win == 0);
    acc_b = (win == 1);
    @(posedge clk);
    if (InitStart) begin
      m_init = 1'b1; m_cnt = 0; m_we = 1'b0;
    end else if (m_init) begin
      m_we = 1'b1; m_wreg = m_cnt; m_wdata = INIT_VAL;
      if (m_cnt == 15) begin m_init = 1'b0; m_cnt = 0; end
      else m_cnt++;
    end else if (win >= 0) begin
      m_ptr = 1 - win;
      r = (win == 1) ? int'(B_Reg) : int'(A_Reg);
      if (r == 0) m_we = 1'b0;
      else begin
        m_we = 1'b1; m_wreg = r;
        m_wdata = (win == 1) ? int'(B_Data) : int'(A_Data);
      end
    end else begin
      m_we = 1'b0;
    end
    #1;
    check("RegWrite", RegWrite, m_we);
    if (m_we) begin
      check("WriteRegister", WriteRegister, m_wreg);
      check("WriteData", WriteData, m_wdata);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd3, 16'h00AB, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3, 16'h00AB, 1'b1};
    tbl[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h00AB, 1'b1};
    tbl[2] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b1, 1'b1, 4'd5, 16'h5555, 1'b1};
    tbl[3] = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b1, 1'b0, 1'b1, 4'd1, 16'h1111, 1'b1};
    tbl[4] = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 1'b1, 4'd2, 16'h2222, 1'b1};
    tbl[5] = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b1, 1'b0, 1'b1, 4'd1, 16'h1111, 1'b1};
    tbl[6] = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 1'b1, 4'd2, 16'h2222, 1'b1};
    tbl[7] = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0};
    tbl[8] = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 1'b1, 4'd2, 16'h2222, 1'b1};
    tbl[9] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd2, 16'h2222, 1'b1};

    // Power-up clear with both requesters pushing; neither may be accepted.
    do_reset();
    A_Valid = 1'b1; A_Reg = 4'd9; A_Data = 16'h9999;
    B_Valid = 1'b1; B_Reg = 4'd8; B_Data = 16'h8888;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("init_we", RegWrite, 1);
      check("init_reg", WriteRegister, i);
      check("init_data", WriteData, INIT_VAL);
    end
    check("busy_after_init", Busy, 0);

    for (int i = 0; i < 10; i++) begin
      A_Valid = tbl[i].av; A_Reg = tbl[i].ar; A_Data = tbl[i].ad;
      B_Valid = tbl[i].bv; B_Reg = tbl[i].br; B_Data = tbl[i].bd;
      cycle();
      check($sformatf("vec%0d_A_Ready", i), smp_a, tbl[i].ea);
      check($sformatf("vec%0d_B_Ready", i), smp_b, tbl[i].eb);
      check($sformatf("vec%0d_RegWrite", i), RegWrite, tbl[i].ewe);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_WriteRegister", i), WriteRegister, tbl[i].ereg);
        check($sformatf("vec%0d_WriteData", i), WriteData, tbl[i].edat);
      end
    end

    // InitStart collides with a B request; B must wait out the full clear.
    A_Valid = 1'b0;
    InitStart = 1'b1; B_Valid = 1'b1; B_Reg = 4'd7; B_Data = 16'h7777;
    cycle();
    check("initstart_B_Ready", smp_b, 0);
    check("initstart_Busy", Busy, 1);
    check("initstart_RegWrite", RegWrite, 0);
    InitStart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("reinit_B_Ready", smp_b, 0);
      check("reinit_reg", WriteRegister, i);
    end
    cycle();
    check("post_reinit_B_Ready", smp_b, 1);
    check("post_reinit_RegWrite", RegWrite, 1);
    check("post_reinit_reg", WriteRegister, 7);
    check("post_reinit_data", WriteData, 16'h7777);
    B_Valid = 1'b0;

    // Randomized traffic; requesters keep a request until it is accepted.
    for (int n = 0; n < 400; n++) begin
      if (!A_Valid || acc_a) begin
        A_Valid = 1'($urandom_range(0, 1));
        A_Reg   = 4'($urandom_range(0, 15));
        A_Data  = 16'($urandom);
      end
      if (!B_Valid || acc_b) begin
        B_Valid = 1'($urandom_range(0, 1));
        B_Reg   = 4'($urandom_range(0, 15));
        B_Data  = 16'($urandom);
      end
      InitStart = ($urandom_range(0, 49) == 0);
      cycle();
    end
    InitStart = 1'b0;
    A_Valid = 1'b0; B_Valid = 1'b0;

    // Reset in the middle of the clear sequence.
    do_reset();
    for (int i = 0; i < 8; i++) cycle();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_RegWrite", RegWrite, 0);
    check("midrst_WriteRegister", WriteRegister, 0);
    check("midrst_WriteData", WriteData, 0);
    check("midrst_Busy", Busy, 1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("rerun_we", RegWrite, 1);
      check("rerun_reg", WriteRegister, i);
    end
    check("rerun_busy_done", Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
